// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter: three requesters share four external Load-enabled
// registers through a single reg_load/reg_d port, one write per grant.
module reg_write_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic [2:0]           req,
  input  logic [5:0]           addr,
  input  logic [3*WIDTH-1:0]   data,
  output logic [2:0]           ack,
  output logic [3:0]           reg_load,
  output logic [WIDTH-1:0]     reg_d,
  output logic                 busy,
  output logic [1:0]           grant_id,
  output logic [15:0]          wr_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_ACK   = 2'd2;

  logic [1:0]       state;
  logic [1:0]       ptr;
  logic [1:0]       addr_q;
  logic [WIDTH-1:0] data_q;
  logic             found;
  logic [1:0]       winner;
  logic [2:0]       cand;

  // Search ptr, ptr+1, ptr+2 (mod 3); first asserted request wins.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    cand   = 3'd0;
    for (int k = 0; k < 3; k++) begin
      cand = {1'b0, ptr} + 3'(k);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (!found && req[cand[1:0]]) begin
        found  = 1'b1;
        winner = cand[1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state    <= S_IDLE;
      ptr      <= 2'd0;
      grant_id <= 2'd0;
      addr_q   <= 2'd0;
      data_q   <= '0;
      wr_cnt   <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            grant_id <= winner;
            addr_q   <= addr[winner*2 +: 2];
            data_q   <= data[winner*WIDTH +: WIDTH];
            state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          wr_cnt <= wr_cnt + 16'd1;
          state  <= S_ACK;
        end
        S_ACK: begin
          ptr   <= (grant_id == 2'd2) ? 2'd0 : grant_id + 2'd1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so an asynchronous clear kills them at once.
  always_comb begin
    reg_load = 4'b0000;
    ack      = 3'b000;
    if (state == S_WRITE) reg_load[addr_q] = 1'b1;
    if (state == S_ACK && grant_id != 2'd3) ack[grant_id] = 1'b1;
  end

  assign reg_d = data_q;
  assign busy  = (state != S_IDLE);

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, data width of each shared register.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: clear  input  1  reset, asynchronous, active-high.
REQ-004 Port: req  input  3  per-requester write request, bit i = requester i.
REQ-005 Port: addr  input  6  packed target register index, {addr2,addr1,addr0}, 2 bits each.
REQ-006 Port: data  input  3*WIDTH  packed write data, requester i at bits [i*WIDTH +: WIDTH].
REQ-007 Port: ack  output  3  one-cycle completion pulse to requester i.
REQ-008 Port: reg_load  output  4  one-hot Load strobe to shared registers 0..3.
REQ-009 Port: reg_d  output  WIDTH  D input driven to all four shared registers.
REQ-010 Port: busy  output  1  high while a grant is in progress.
REQ-011 Port: grant_id  output  2  index of current winner, valid only while busy=1.
REQ-012 Port: wr_cnt  output  16  count of completed register writes.

Function
REQ-013 Block shall arbitrate write access to four external WIDTH-bit Load-enabled registers among three requesters.
REQ-014 FSM states shall be IDLE, WRITE, ACK; encoding free.
REQ-015 IDLE: if any req bit is set at a rising edge, the block shall select a winner, latch its addr and data, and enter WRITE; else remain IDLE.
REQ-016 Winner selection shall be round-robin: search order ptr, ptr+1, ptr+2 (mod 3); first set req bit wins.
REQ-017 WRITE (exactly one cycle): reg_load shall be one-hot at the latched addr; reg_d shall equal the latched data; next state ACK.
REQ-018 ACK (exactly one cycle): ack[grant_id]=1, reg_load=0; next state IDLE.
REQ-019 On leaving ACK, ptr shall become (grant_id+1) mod 3.
REQ-020 Outside WRITE, reg_load shall be 4'b0000; reg_d shall be don't-care but stable (hold latched data).
REQ-021 Outside ACK, ack shall be 3'b000; at most one ack bit is ever set.
REQ-022 busy shall be 1 in WRITE and ACK, 0 in IDLE.
REQ-023 Latency: req sampled at edge N -> reg_load high in cycle N..N+1 -> ack high in cycle N+1..N+2 -> next grant sampled no earlier than edge N+3.
REQ-024 Requester shall hold req, addr, data stable until ack; changes after the IDLE sampling edge shall not affect the in-flight write.
REQ-025 A req still high in the cycle after its ack shall be treated as a new request, subject to round-robin order.
REQ-026 Simultaneous requests to the same register index shall be serialised; last granted writer's data remains.
REQ-027 wr_cnt shall increment by 1 on each edge leaving WRITE; wrap 16'hFFFF -> 16'h0000.
REQ-028 req bits deasserting while busy shall not abort the in-flight write.

Reset
REQ-029 clear=1 shall immediately force state IDLE, ptr=0, reg_load=0, ack=0, busy=0, grant_id=0, wr_cnt=0, latched addr/data=0.
REQ-030 clear asserted during WRITE shall suppress reg_load in the same cycle; no ack shall issue for the aborted write and wr_cnt shall not increment.
REQ-031 After clear deasserts, first arbitration shall occur at the next rising edge with ptr=0.

Verification
REQ-032 Single request: req=3'b001, addr0=2, data0=32'hDEADBEEF -> reg_load=4'b0100 with reg_d=32'hDEADBEEF for one cycle, then ack=3'b001, wr_cnt=1.
REQ-033 Contention: req=3'b111 held through three acks from reset -> acks in order 0,1,2; wr_cnt=3; no cycle with two reg_load bits set.
REQ-034 Fairness: req1 and req2 held continuously, requester 0 idle -> grants alternate 1,2,1,2.
REQ-035 Same-index conflict: req0 data 32'h1111 and req2 data 32'h2222 both to addr 3, ptr=0 -> register 3 ends at 32'h2222.
REQ-036 Reset mid-write: clear pulsed during WRITE -> reg_load drops immediately, no ack, wr_cnt=0, next grant goes to lowest set req index.
REQ-037 Counter wrap: preload via 65536 writes -> wr_cnt returns to 16'h0000 after write 65536.
